// File: rtl/i2c_slave_shift_phy_if.sv
// Command/result port bundle between the I2C slave protocol FSM and the shift PHY.
// The PHY takes the slave modport; the protocol FSM (or a bench) takes the master modport.
interface i2c_slave_shift_phy_if #(
  parameter int MAX_BITS = 9,
  parameter int BC_W     = $clog2(MAX_BITS + 1)
);
  logic                cmd_valid_i;
  logic                cmd_ready_o;
  logic [1:0]          cmd_i;
  logic [BC_W-1:0]     bit_cnt_i;
  logic [MAX_BITS-1:0] wdata_i;
  logic [MAX_BITS-1:0] rdata_o;
  logic                done_o;
  logic                abort_o;

  modport slave (
    input  cmd_valid_i, cmd_i, bit_cnt_i, wdata_i,
    output cmd_ready_o, rdata_o, done_o, abort_o
  );

  modport master (
    output cmd_valid_i, cmd_i, bit_cnt_i, wdata_i,
    input  cmd_ready_o, rdata_o, done_o, abort_o
  );
endinterface

// File: rtl/i2c_slave_shift_phy.sv
// I2C slave PHY: filtered SDA/SCL, START/STOP detection, multi-bit READ/WRITE shift per command.
// Optional SCL stretching after each completed command when I2C_SLAVE_CLK_STRETCH_EN is defined.
module i2c_slave_shift_phy #(
  parameter int CLK_T         = 10000,
  parameter int SPIKE_FILT_PS = 50000,
  parameter int DATA_HOLD_PS  = 300000,
  parameter int MAX_BITS      = 9
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic                        sda_i,
  output logic                        sda_o,
  output logic                        sda_oe,
  input  logic                        scl_i,
  output logic                        scl_o,
  output logic                        scl_oe,
  i2c_slave_shift_phy_if.slave        cmd,
  output logic                        start_o,
  output logic                        stop_o,
  output logic                        bus_busy_o
);

  localparam int FILT_RAW   = SPIKE_FILT_PS / CLK_T;
  localparam int FILT_L     = (FILT_RAW < 2) ? 2 : FILT_RAW;
  localparam int HOLD_TICKS = DATA_HOLD_PS / CLK_T + 1;
  localparam int HC_W       = $clog2(HOLD_TICKS + 1);
  localparam int BC_W       = $clog2(MAX_BITS + 1);

  localparam logic [1:0] CMD_READ  = 2'd1;
  localparam logic [1:0] CMD_WRITE = 2'd2;

  typedef enum logic [1:0] {IDLE, WAIT_POS, WAIT_NEG, HOLD} state_t;

  // ---------------- input conditioning ----------------
  logic [1:0]        sync1, sync2;
  logic [FILT_L-1:0] scl_hist, sda_hist;
  logic              scl_f, sda_f, scl_f_d, sda_f_d;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync1    <= 2'b11;
      sync2    <= 2'b11;
      scl_hist <= '1;
      sda_hist <= '1;
      scl_f    <= 1'b1;
      sda_f    <= 1'b1;
      scl_f_d  <= 1'b1;
      sda_f_d  <= 1'b1;
    end else begin
      sync1    <= {scl_i, sda_i};
      sync2    <= sync1;
      scl_hist <= {scl_hist[FILT_L-2:0], sync2[1]};
      sda_hist <= {sda_hist[FILT_L-2:0], sync2[0]};
      if (&scl_hist)       scl_f <= 1'b1;
      else if (~|scl_hist) scl_f <= 1'b0;
      if (&sda_hist)       sda_f <= 1'b1;
      else if (~|sda_hist) sda_f <= 1'b0;
      scl_f_d  <= scl_f;
      sda_f_d  <= sda_f;
    end
  end

  logic scl_rise, scl_fall, sda_rise, sda_fall;
  assign scl_rise = scl_f & ~scl_f_d;
  assign scl_fall = ~scl_f & scl_f_d;
  assign sda_rise = sda_f & ~sda_f_d;
  assign sda_fall = ~sda_f & sda_f_d;

  assign start_o = sda_fall & scl_f;
  assign stop_o  = sda_rise & scl_f;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)        bus_busy_o <= 1'b0;
    else if (start_o) bus_busy_o <= 1'b1;
    else if (stop_o)  bus_busy_o <= 1'b0;
  end

  // ---------------- command shift FSM ----------------
  state_t              state_q, state_n;
  logic [BC_W-1:0]     idx_q, idx_n;
  logic                rd_q, rd_n;
  logic [MAX_BITS-1:0] wdata_q, wdata_n;
  logic [MAX_BITS-1:0] sh_q, sh_n;
  logic [MAX_BITS-1:0] rdata_q, rdata_n;
  logic [HC_W-1:0]     hold_q, hold_n;
  logic                done_q, done_n;
  logic                abort_q, abort_n;

  logic                accept, abort_now;
  logic [BC_W-1:0]     n_eff, first_idx;

  always_comb begin
    if (cmd.bit_cnt_i == '0)                     n_eff = BC_W'(1);
    else if (cmd.bit_cnt_i > BC_W'(MAX_BITS))    n_eff = BC_W'(MAX_BITS);
    else                                         n_eff = cmd.bit_cnt_i;
  end
  assign first_idx = n_eff - BC_W'(1);

  assign accept = cmd.cmd_valid_i && (state_q == IDLE) &&
                  ((cmd.cmd_i == CMD_READ) || (cmd.cmd_i == CMD_WRITE));

  // Any SDA movement while a READ waits for SCL low means the master broke the bit.
  assign abort_now = (state_q != IDLE) &&
                     (start_o || stop_o ||
                      ((state_q == WAIT_NEG) && rd_q && (sda_rise || sda_fall)));

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      idx_q   <= '0;
      rd_q    <= 1'b0;
      wdata_q <= '0;
      sh_q    <= '0;
      rdata_q <= '0;
      hold_q  <= '0;
      done_q  <= 1'b0;
      abort_q <= 1'b0;
    end else begin
      state_q <= state_n;
      idx_q   <= idx_n;
      rd_q    <= rd_n;
      wdata_q <= wdata_n;
      sh_q    <= sh_n;
      rdata_q <= rdata_n;
      hold_q  <= hold_n;
      done_q  <= done_n;
      abort_q <= abort_n;
    end
  end

  always_comb begin
    state_n = state_q;
    idx_n   = idx_q;
    rd_n    = rd_q;
    wdata_n = wdata_q;
    sh_n    = sh_q;
    rdata_n = rdata_q;
    hold_n  = hold_q;
    done_n  = 1'b0;
    abort_n = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (accept) begin
          state_n = WAIT_POS;
          idx_n   = first_idx;
          rd_n    = (cmd.cmd_i == CMD_READ);
          wdata_n = cmd.wdata_i;
          sh_n    = '0;
        end
      end
      WAIT_POS: begin
        if (scl_rise) begin
          state_n = WAIT_NEG;
          if (rd_q) sh_n = {sh_q[MAX_BITS-2:0], sda_f};
        end
      end
      WAIT_NEG: begin
        if (scl_fall) begin
          if (!rd_q) begin
            state_n = HOLD;
            hold_n  = '0;
          end else if (idx_q == '0) begin
            state_n = IDLE;
            done_n  = 1'b1;
            rdata_n = sh_q;
          end else begin
            state_n = WAIT_POS;
            idx_n   = idx_q - BC_W'(1);
          end
        end
      end
      HOLD: begin
        if (hold_q == HC_W'(HOLD_TICKS - 1)) begin
          if (idx_q == '0) begin
            state_n = IDLE;
            done_n  = 1'b1;
          end else begin
            state_n = WAIT_POS;
            idx_n   = idx_q - BC_W'(1);
          end
        end else begin
          hold_n = hold_q + HC_W'(1);
        end
      end
      default: state_n = IDLE;
    endcase

    if (abort_now) begin
      state_n = IDLE;
      done_n  = 1'b0;
      abort_n = 1'b1;
      rdata_n = rdata_q;
    end
  end

  assign cmd.cmd_ready_o = (state_q == IDLE);
  assign cmd.rdata_o     = rdata_q;
  assign cmd.done_o      = done_q;
  assign cmd.abort_o     = abort_q;

  // The first bit is put on the wire in the accept cycle to give it a full SCL low phase.
  assign sda_oe = ((state_q != IDLE) && !rd_q && !wdata_q[idx_q]) ||
                  (accept && (cmd.cmd_i == CMD_WRITE) && !cmd.wdata_i[first_idx]);
  assign sda_o  = 1'b0;
  assign scl_o  = 1'b0;

`ifdef I2C_SLAVE_CLK_STRETCH_EN
  logic            stretch_arm;
  logic [HC_W-1:0] setup_q;
  logic            stretch_idle;

  assign stretch_idle = stretch_arm && (state_q == IDLE) && !scl_f;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      stretch_arm <= 1'b0;
      setup_q     <= '0;
    end else begin
      if (start_o || stop_o || accept) stretch_arm <= 1'b0;
      else if (done_q)                 stretch_arm <= 1'b1;

      if (abort_now)                    setup_q <= '0;
      else if (accept && stretch_idle)  setup_q <= HC_W'(HOLD_TICKS);
      else if (setup_q != '0)           setup_q <= setup_q - HC_W'(1);
    end
  end

  assign scl_oe = stretch_idle || (setup_q != '0);
`else
  assign scl_oe = 1'b0;
`endif

endmodule

// File: tb/tb_i2c_slave_shift_phy.sv
// Bench for i2c_slave_shift_phy: a bus master model drives SDA/SCL, a scoreboard checks done/abort results.
`timescale 1ns/1ps
module tb_i2c_slave_shift_phy;
  localparam int MAX_BITS   = 9;
  localparam int HP         = 60;
  localparam int HOLD_TICKS = 31;

  typedef struct packed {
    logic [1:0] kind;   // 2'b10 done, 2'b01 abort
    logic [8:0] rdata;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic sda_m = 1'b1;
  logic scl_m = 1'b1;
  logic sda_i, scl_i, sda_o, sda_oe, scl_o, scl_oe;
  logic start_o, stop_o, bus_busy_o;

  int   total = 0;
  int   bad = 0;
  int   start_cnt = 0;
  int   stop_cnt = 0;
  exp_t sb_q[$];
  logic [8:0] last_rd = '0;

  assign sda_i = sda_m & ~sda_oe;
  assign scl_i = scl_m & ~scl_oe;

  i2c_slave_shift_phy_if #(.MAX_BITS(MAX_BITS)) bus ();

  i2c_slave_shift_phy dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .sda_i      (sda_i),
    .sda_o      (sda_o),
    .sda_oe     (sda_oe),
    .scl_i      (scl_i),
    .scl_o      (scl_o),
    .scl_oe     (scl_oe),
    .cmd        (bus),
    .start_o    (start_o),
    .stop_o     (stop_o),
    .bus_busy_o (bus_busy_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, act, exp);
    end
  endtask

  always @(negedge clk) begin : mon
    exp_t e;
    if (!rst) begin
      if (start_o) start_cnt++;
      if (stop_o)  stop_cnt++;
      if (bus.done_o || bus.abort_o) begin
        if (sb_q.size() == 0) begin
          check("sb_unexpected", {30'd0, bus.done_o, bus.abort_o}, 32'd0);
        end else begin
          e = sb_q.pop_front();
          check("sb_kind",  {30'd0, bus.done_o, bus.abort_o}, {30'd0, e.kind});
          check("sb_rdata", {23'd0, bus.rdata_o}, {23'd0, e.rdata});
        end
      end
    end
  end

  initial begin
    repeat (80000) @(posedge clk);
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "bench timeout");
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
  endtask

  task automatic wait_scl_high();
    for (int i = 0; i < 3000 && scl_i !== 1'b1; i++) @(posedge clk);
    check("scl_high", {31'd0, scl_i}, 32'd1);
  endtask

  // One master clock pulse; SCL is low on entry and exit.
  task automatic bit_x(input logic d, output logic smp, output logic held);
    sda_m = d;
    tick(HP);
    scl_m = 1'b1;
    wait_scl_high();
    tick(HP / 2);
    smp = sda_i;
    tick(HP / 2);
    scl_m = 1'b0;
    tick(30);
    held = sda_i;
    tick(HP - 30);
  endtask

  task automatic start_c();
    sda_m = 1'b0;
    tick(HP);
    scl_m = 1'b0;
    tick(HP);
  endtask

  task automatic rstart_c();
    sda_m = 1'b1;
    tick(HP);
    scl_m = 1'b1;
    wait_scl_high();
    tick(HP);
    start_c();
  endtask

  task automatic stop_c();
    sda_m = 1'b0;
    tick(HP);
    scl_m = 1'b1;
    wait_scl_high();
    tick(HP);
    sda_m = 1'b1;
    tick(HP);
  endtask

  task automatic issue(input logic [1:0] c, input logic [3:0] n, input logic [8:0] w);
    @(negedge clk);
    bus.cmd_valid_i = 1'b1;
    bus.cmd_i       = c;
    bus.bit_cnt_i   = n;
    bus.wdata_i     = w;
    for (int i = 0; i < 500 && bus.cmd_ready_o !== 1'b1; i++) @(negedge clk);
    check("cmd_ready", {31'd0, bus.cmd_ready_o}, 32'd1);
    @(posedge clk);
    #1;
    bus.cmd_valid_i = 1'b0;
  endtask

  task automatic rd_cmd(input logic [3:0] cnt, input int nbits, input logic [8:0] val);
    logic s, h;
    sb_q.push_back('{kind: 2'b10, rdata: val});
    last_rd = val;
    issue(2'd1, cnt, 9'd0);
    for (int i = nbits - 1; i >= 0; i--) bit_x(val[i], s, h);
    check("rd_done_seen", sb_q.size(), 32'd0);
  endtask

  task automatic wr_cmd(input logic [3:0] n, input logic [8:0] w, input logic meas);
    logic s, h;
    int   cnt;
    sb_q.push_back('{kind: 2'b10, rdata: last_rd});
    issue(2'd2, n, w);
    if (meas) begin
      cnt = 0;
      for (int i = 0; i < 200; i++) begin
        @(negedge clk);
        if (!scl_oe) break;
        cnt++;
      end
`ifdef I2C_SLAVE_CLK_STRETCH_EN
      check("stretch_len", cnt, HOLD_TICKS);
`else
      check("stretch_len", cnt, 32'd0);
`endif
      check("busy_not_ready", {31'd0, bus.cmd_ready_o}, 32'd0);
    end
    for (int i = int'(n) - 1; i >= 0; i--) begin
      bit_x(1'b1, s, h);
      check("wr_sample", {31'd0, s}, {31'd0, w[i]});
      check("wr_hold",   {31'd0, h}, {31'd0, w[i]});
    end
    check("wr_release", {31'd0, sda_oe}, 32'd0);
  endtask

  // READ that is killed after nbits by STOP (use_stop) or a repeated START.
  task automatic rd_abort(input int nbits, input logic [8:0] val, input logic use_stop);
    logic s, h;
    sb_q.push_back('{kind: 2'b01, rdata: last_rd});
    issue(2'd1, 4'd8, 9'd0);
    for (int i = 7; i > 7 - nbits; i--) bit_x(val[i], s, h);
    if (use_stop) stop_c();
    else          rstart_c();
    check("ab_ready", {31'd0, bus.cmd_ready_o}, 32'd1);
    check("ab_rdata", {23'd0, bus.rdata_o}, {23'd0, last_rd});
    check("ab_drained", sb_q.size(), 32'd0);
  endtask

  initial begin
    bus.cmd_valid_i = 1'b0;
    bus.cmd_i       = 2'd0;
    bus.bit_cnt_i   = '0;
    bus.wdata_i     = '0;
    tick(4);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst_ready",  {31'd0, bus.cmd_ready_o}, 32'd1);
    check("rst_sda_oe", {31'd0, sda_oe}, 32'd0);
    check("rst_scl_oe", {31'd0, scl_oe}, 32'd0);
    check("rst_busy",   {31'd0, bus_busy_o}, 32'd0);
    check("rst_rdata",  {23'd0, bus.rdata_o}, 32'd0);

    // Reserved and NONE commands are ignored.
    bus.cmd_valid_i = 1'b1;
    bus.cmd_i       = 2'd3;
    bus.bit_cnt_i   = 4'd8;
    @(negedge clk);
    check("rsv_ready", {31'd0, bus.cmd_ready_o}, 32'd1);
    bus.cmd_i = 2'd0;
    @(negedge clk);
    check("none_ready", {31'd0, bus.cmd_ready_o}, 32'd1);
    check("none_sda_oe", {31'd0, sda_oe}, 32'd0);
    bus.cmd_valid_i = 1'b0;

    // 30 ns spikes on an idle bus must be filtered out.
    scl_m = 1'b0; tick(3); scl_m = 1'b1; tick(20);
    sda_m = 1'b0; tick(3); sda_m = 1'b1; tick(20);
    sda_m = 1'b0; scl_m = 1'b0; tick(3); sda_m = 1'b1; scl_m = 1'b1; tick(20);
    check("glitch_start", start_cnt, 32'd0);
    check("glitch_stop",  stop_cnt, 32'd0);
    check("glitch_busy",  {31'd0, bus_busy_o}, 32'd0);

    // Transaction 1: address byte in, ACK, data byte out, master ACK, aborted read on STOP.
    start_c();
    check("start_cnt1", start_cnt, 32'd1);
    check("busy_set",   {31'd0, bus_busy_o}, 32'd1);
    rd_cmd(4'd8, 8, 9'h03C);
    check("rdata_3c", {23'd0, bus.rdata_o}, 32'h03C);
    wr_cmd(4'd1, 9'h000, 1'b0);
`ifdef I2C_SLAVE_CLK_STRETCH_EN
    scl_m = 1'b1;
    tick(1000);
    check("stretch_hold", {31'd0, scl_i}, 32'd0);
`else
    tick(1000);
    check("no_stretch", {31'd0, scl_oe}, 32'd0);
`endif
    wr_cmd(4'd8, 9'h0A5, 1'b1);
    rd_cmd(4'd1, 1, 9'h000);
    last_rd = 9'h000;
    rd_abort(3, 9'h0B4, 1'b1);
    check("busy_clr", {31'd0, bus_busy_o}, 32'd0);

    // Transaction 2: clamped and zero bit counts, repeated START abort, then STOP abort.
    start_c();
    rd_cmd(4'd15, 9, 9'h1A5);
    rd_cmd(4'd0, 1, 9'h001);
    rd_abort(2, 9'h0FF, 1'b0);
    check("rs_busy", {31'd0, bus_busy_o}, 32'd1);
    rd_abort(0, 9'h000, 1'b1);
    check("busy_clr2", {31'd0, bus_busy_o}, 32'd0);

    tick(100);
    check("start_total", start_cnt, 32'd3);
    check("stop_total",  stop_cnt, 32'd2);
    check("sb_drain",    sb_q.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/i2c_slave_shift_phy.md
Name: i2c_slave_shift_phy

Overview:
- Next-generation I2C slave physical layer. Performs multi-bit (1..MAX_BITS) shift transfers per command, not single bits.
- Features: parametrised glitch filter and hold time, explicit valid/ready command handshake, abort on unexpected START/STOP, bus-busy tracking, optional SCL clock stretching.
- Sits between the SDA/SCL pad buffers and the slave protocol FSM (address match, register access).

Parameters:
- CLK_T, 10000, clk_i period in ps.
- SPIKE_FILT_PS, 50000, minimum stable time (ps) before a line change is accepted; FILT_L = max(2, SPIKE_FILT_PS/CLK_T) samples.
- DATA_HOLD_PS, 300000, SDA hold after SCL falling edge; HOLD_TICKS = DATA_HOLD_PS/CLK_T + 1.
- MAX_BITS, 9, maximum bits per command (byte + ACK); BC_W = $clog2(MAX_BITS+1).

Ports:
- clk_i  in  1  clock
- rst_i  in  1  asynchronous active-high reset
- sda_i  in  1  SDA pad input
- sda_o  out  1  SDA drive value, constant 0
- sda_oe  out  1  SDA pull-low enable
- scl_i  in  1  SCL pad input
- scl_o  out  1  SCL drive value, constant 0
- scl_oe  out  1  SCL pull-low enable (stretching)
- cmd_valid_i  in  1  command request
- cmd_ready_o  out  1  PHY can accept a command
- cmd_i  in  2  0 NONE, 1 READ, 2 WRITE, 3 reserved
- bit_cnt_i  in  BC_W  bits to transfer
- wdata_i  in  MAX_BITS  write data, right-aligned, MSB first on wire
- rdata_o  out  MAX_BITS  read data, right-aligned
- done_o  out  1  command completed pulse
- abort_o  out  1  command killed by START/STOP pulse
- start_o  out  1  START (or repeated START) detected pulse
- stop_o  out  1  STOP detected pulse
- bus_busy_o  out  1  high between START and STOP

Behaviour:
- Reset (rst_i, asynchronous, active-high, clock clk_i):
  - Synchronisers, filter history, filtered lines and their delayed copies all reset to 1.
  - FSM to IDLE.
  - All outputs 0, except cmd_ready_o = 1.
- Input path:
  - 2-FF synchroniser, then an FILT_L-deep history.
  - The filtered line changes only when the whole history is all-1 or all-0.
  - Edges come from filtered vs. 1-cycle-delayed filtered.
- Bus conditions:
  - start_o = SDA negedge while SCL filtered high; stop_o = SDA posedge while SCL high. Each is a 1-cycle pulse.
  - bus_busy_o set by START, cleared by STOP.
- Handshake:
  - Command accepted when cmd_valid_i && cmd_ready_o && cmd_i in {1,2}. cmd_ready_o = (state == IDLE).
  - cmd_i of 0 or 3 with valid: ignored, stays IDLE.
  - bit_cnt_i and wdata_i are latched on accept. bit_cnt 0 is treated as 1; values > MAX_BITS are clamped to MAX_BITS.
- FSM states: IDLE, WAIT_POS, WAIT_NEG, HOLD.
  - IDLE -> WAIT_POS on accept. The bit counter is loaded with N-1 (current bit index).
  - WAIT_POS -> WAIT_NEG on SCL posedge. READ samples filtered SDA into a shift register on this edge.
  - WAIT_NEG, READ:
    - on SCL negedge: index 0 -> IDLE with done_o; otherwise decrement index -> WAIT_POS.
    - SDA edge while here -> abort.
  - WAIT_NEG, WRITE: on SCL negedge -> HOLD, hold counter cleared.
  - HOLD: the current bit stays driven. When the counter reaches HOLD_TICKS: index 0 -> IDLE with done_o; otherwise decrement index -> WAIT_POS (next bit presented).
- Write drive: sda_oe = !wdata[index] in WAIT_POS, WAIT_NEG and HOLD of a WRITE, and in the accept cycle. Otherwise 0.
- done_o: 1-cycle pulse. READ: cycle after the final negedge. WRITE: cycle after hold expiry.
- rdata_o: updated coincident with done_o; holds until the next READ completes. Upper bits above N are 0.
- Abort:
  - Trigger: start_o or stop_o while state != IDLE.
  - Next cycle: IDLE, sda_oe = 0, abort_o pulse, no done_o, rdata_o unchanged.
  - START/STOP in IDLE: only start_o/stop_o.
- Simultaneous SCL negedge and SDA edge in WAIT_NEG: abort wins.
- Reset mid-transfer: immediate release of SDA/SCL; no done_o or abort_o generated.

Optional Feature:
- Macro: I2C_SLAVE_CLK_STRETCH_EN.
- Defined:
  - A stretch flag arms on done_o and disarms on start_o, stop_o or accept.
  - While armed, IDLE, and SCL filtered low: scl_oe = 1, holding SCL low until the next command is accepted.
  - After accept, scl_oe stays 1 for HOLD_TICKS more cycles (SDA setup), then releases.
  - Abort releases scl_oe in the same cycle as sda_oe.
- Undefined: scl_oe tied 0; no stretch logic.

Test Plan:
- Reset → cmd_ready_o = 1, sda_oe = scl_oe = 0, bus_busy_o = 0, rdata_o = 0.
- START, then READ N=8 with master sending 0x3C → rdata_o = 9'h03C with done_o pulse 1 cycle after 8th SCL negedge; no abort_o.
- WRITE N=8 wdata = 0xA5 → sda_oe follows !1,0,1,0,0,1,0,1 per SCL period, changing HOLD_TICKS (31 at defaults) cycles after each negedge; done_o after last hold.
- WRITE N=1 wdata = 0 (ACK) → sda_oe high from accept through 9th negedge + 31 cycles, then 0.
- READ N=8, STOP after 3rd bit → abort_o pulse, state IDLE, no done_o, bus_busy_o = 0, rdata_o unchanged.
- 30 ns low glitch on SCL and SDA (FILT_L = 5) → no edges, no start_o; with I2C_SLAVE_CLK_STRETCH_EN, no cmd for 10 us after done_o → SCL held low until accept + 31 cycles.
